floo_mcast_rsp_merge: RTL and testbench
=======================================

# floo_mcast_rsp_merge

Merges write responses for multicast transactions into one response per transaction. It sits directly downstream of the response path of the in-order (NoRoB) reorder stage in the narrow/wide chimney. For every multicast AW accepted upstream, it receives the expected response count (the replication coefficient). It then absorbs that many B responses for the same AXI ID and emits one merged B response carrying the worst-case status.

## Interface
- IdWidth, default 4: AXI ID width; the block has 2**IdWidth tracking slots, one per ID.
- MaxFanout, default 16: maximum replication count per transaction.
- CntWidth, default $clog2(MaxFanout)+1: width of count fields.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- exp_valid_i  in  1  expectation push valid.
- exp_ready_o  out  1  expectation push ready.
- exp_id_i  in  IdWidth  AXI ID of the issued transaction.
- exp_count_i  in  CntWidth  number of B responses to merge.
- rsp_valid_i  in  1  incoming B response valid.
- rsp_ready_o  out  1  incoming B response ready.
- rsp_id_i  in  IdWidth  incoming B ID.
- rsp_resp_i  in  2  incoming AXI BRESP.
- rsp_valid_o  out  1  merged B valid.
- rsp_ready_i  in  1  merged B ready.
- rsp_id_o  out  IdWidth  merged B ID.
- rsp_resp_o  out  2  merged BRESP.
- unexpected_o  out  1  one-cycle pulse when a response hits an empty slot.

## Operation
- Each slot holds: valid, remaining count (CntWidth bits) and accumulated resp (2 bits). At most one merge is outstanding per ID.
- **Expectation push**
  - exp_ready_o = !slot[exp_id_i].valid, OR that slot's final response is accepted in the same cycle (same-cycle reuse).
  - On handshake the slot is loaded with valid=1, remaining=exp_count_i, acc=EXOKAY.
  - exp_count_i==0 is treated as 1.
  - Values above MaxFanout are saturated to MaxFanout.
- **Response intake**, slot s = slot[rsp_id_i]:
  - s invalid: rsp_ready_o=1. The beat is dropped and unexpected_o pulses the next cycle.
  - s valid and remaining>1 (non-final): rsp_ready_o=1. On handshake: remaining-=1, acc=merge(acc, rsp_resp_i).
  - s valid and remaining==1 (final): rsp_ready_o = !out_valid || rsp_ready_i. On handshake the slot is cleared and the output register loads id=rsp_id_i, resp=merge(acc, rsp_resp_i).
- **merge() priority:** DECERR(3) > SLVERR(2) > OKAY(0) > EXOKAY(1). The result is EXOKAY only if every merged beat was EXOKAY.
- **Output:** a one-entry register with AXI valid/ready semantics. rsp_id_o and rsp_resp_o are held stable while rsp_valid_o && !rsp_ready_i.
- Merged responses leave in completion order, not issue order, across different IDs.
- **Same-cycle push and non-final response, same ID:** the push is stalled (exp_ready_o=0). The response proceeds.

## Timing
- **Reset:** all slots invalid; rsp_valid_o=0; rsp_id_o=0; rsp_resp_o=0; unexpected_o=0.
  - exp_ready_o and rsp_ready_o are forced to 0 while rst_i=1.
  - A reset mid-merge discards all partial state; no merged response is emitted for discarded slots.
- **Latency, final response to rsp_valid_o:** 1 cycle.
- **Throughput:** 1 merged response per cycle when rsp_ready_i is held high.
- **Input readiness:** exp_ready_o and rsp_ready_o are combinational from slot state and the output register. No input valid may depend on them.
- **unexpected_o:** registered, exactly one cycle per dropped beat.

## Configuration
- FLOO_MCAST_RSP_BYPASS_EN defined: a final response arriving when the output register is empty is presented combinationally on rsp_*_o in the same cycle (0-cycle latency).
  - It is registered only if rsp_ready_i=0.
  - rsp_ready_o for a final beat then equals 1 whenever the output register is empty.
- Undefined: the output is always registered (1-cycle latency as above).

## Test plan
- **Fanout merge:** push (id=3, count=4), then 4 OKAY beats on id 3 -> exactly one rsp_valid_o with id=3, resp=OKAY, 1 cycle after the 4th beat; exp_ready_o for id 3 returns to 1.
- **Error priority:** count=3, beats EXOKAY, SLVERR, DECERR -> resp=DECERR. Count=2, beats EXOKAY, EXOKAY -> resp=EXOKAY. Count=2, beats EXOKAY, OKAY -> resp=OKAY.
- **Backpressure:** hold rsp_ready_i=0 with one merged response pending -> the next final beat (other ID) sees rsp_ready_o=0 while non-final beats are still accepted; rsp_id_o/rsp_resp_o are stable until the handshake.
- **Slot reuse:** final beat for id 5 and a push for id 5 (count=2) in the same cycle -> both handshake; two more beats yield a second merged response.
- **Edge counts:** push count=0 -> one beat completes it. Push count=31 with MaxFanout=16 -> exactly 16 beats complete it.
- **Error and reset:** a beat on an empty id 7 -> dropped, unexpected_o high for exactly 1 cycle. Assert rst_i mid-merge -> all outputs at reset values, and later beats on that ID flag unexpected_o.

Source files
------------

// File: rtl/floo_mcast_rsp_merge.sv
// floo_mcast_rsp_merge: collapses the replicated B responses of a multicast
// write into a single B response per AXI ID, carrying the worst-case status.
// One tracking slot per ID holds the remaining beat count and the
// accumulated response.
// Optional feature: define FLOO_MCAST_RSP_BYPASS_EN to present a final
// response combinationally when the output register is empty.
module floo_mcast_rsp_merge #(
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned MaxFanout = 16,
  parameter int unsigned CntWidth  = $clog2(MaxFanout) + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                exp_valid_i,
  output logic                exp_ready_o,
  input  logic [IdWidth-1:0]  exp_id_i,
  input  logic [CntWidth-1:0] exp_count_i,
  input  logic                rsp_valid_i,
  output logic                rsp_ready_o,
  input  logic [IdWidth-1:0]  rsp_id_i,
  input  logic [1:0]          rsp_resp_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [IdWidth-1:0]  rsp_id_o,
  output logic [1:0]          rsp_resp_o,
  output logic                unexpected_o
);

  localparam int unsigned NSlots = 2 ** IdWidth;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  // Severity rank: DECERR > SLVERR > OKAY > EXOKAY.
  function automatic logic [1:0] resp_rank(input logic [1:0] r);
    case (r)
      RESP_DECERR: resp_rank = 2'd3;
      RESP_SLVERR: resp_rank = 2'd2;
      RESP_OKAY:   resp_rank = 2'd1;
      default:     resp_rank = 2'd0;
    endcase
  endfunction

  // Keep whichever response is more severe.
  function automatic logic [1:0] merge_resp(input logic [1:0] a, input logic [1:0] b);
    merge_resp = (resp_rank(b) > resp_rank(a)) ? b : a;
  endfunction

  // A zero count still means one beat; counts beyond the fanout limit clamp.
  function automatic logic [CntWidth-1:0] sat_count(input logic [CntWidth-1:0] c);
    if (c == '0) begin
      sat_count = CntWidth'(1);
    end else if (c > CntWidth'(MaxFanout)) begin
      sat_count = CntWidth'(MaxFanout);
    end else begin
      sat_count = c;
    end
  endfunction

  logic                valid_q [NSlots];
  logic                valid_d [NSlots];
  logic [CntWidth-1:0] rem_q   [NSlots];
  logic [CntWidth-1:0] rem_d   [NSlots];
  logic [1:0]          acc_q   [NSlots];
  logic [1:0]          acc_d   [NSlots];

  logic               out_valid_q, out_valid_d;
  logic [IdWidth-1:0] out_id_q, out_id_d;
  logic [1:0]         out_resp_q, out_resp_d;
  logic               unexpected_q, unexpected_d;

  logic                s_valid;
  logic [CntWidth-1:0] s_rem;
  logic                s_final;
  logic [1:0]          s_merged;
  logic                rsp_hs, final_hs, exp_hs;
  logic                bypass, out_load;

  // Look up the slot addressed by the incoming response and derive readiness.
  always_comb begin
    s_valid     = valid_q[rsp_id_i];
    s_rem       = rem_q[rsp_id_i];
    s_final     = s_valid && (s_rem == CntWidth'(1));
    s_merged    = merge_resp(acc_q[rsp_id_i], rsp_resp_i);
    // Only a final beat needs room in the output register.
    rsp_ready_o = !rst_i && (!s_final || !out_valid_q || rsp_ready_i);
    rsp_hs      = rsp_valid_i && rsp_ready_o;
    final_hs    = rsp_hs && s_final;
    // A busy slot can be re-armed only in the cycle its final beat retires.
    exp_ready_o = !rst_i && (!valid_q[exp_id_i] || (final_hs && (rsp_id_i == exp_id_i)));
    exp_hs      = exp_valid_i && exp_ready_o;
  end

  // Next slot state: response consumption first, then a push may re-arm.
  always_comb begin
    valid_d = valid_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    if (rsp_hs && s_valid) begin
      if (s_final) begin
        valid_d[rsp_id_i] = 1'b0;
      end else begin
        rem_d[rsp_id_i] = s_rem - CntWidth'(1);
        acc_d[rsp_id_i] = s_merged;
      end
    end
    if (exp_hs) begin
      valid_d[exp_id_i] = 1'b1;
      rem_d[exp_id_i]   = sat_count(exp_count_i);
      acc_d[exp_id_i]   = RESP_EXOKAY;
    end
  end

  // Output register control; the bypass variant skips the register when idle.
  always_comb begin
`ifdef FLOO_MCAST_RSP_BYPASS_EN
    bypass   = final_hs && !out_valid_q;
    out_load = final_hs && (out_valid_q || !rsp_ready_i);
`else
    bypass   = 1'b0;
    out_load = final_hs;
`endif
    out_valid_d  = out_valid_q;
    out_id_d     = out_id_q;
    out_resp_d   = out_resp_q;
    if (out_load) begin
      out_valid_d = 1'b1;
      out_id_d    = rsp_id_i;
      out_resp_d  = s_merged;
    end else if (rsp_ready_i) begin
      out_valid_d = 1'b0;
    end
    unexpected_d = rsp_hs && !s_valid;
  end

  // Drive the merged response from the register or, when bypassing, the input.
  always_comb begin
    rsp_valid_o  = out_valid_q || bypass;
    rsp_id_o     = bypass ? rsp_id_i : out_id_q;
    rsp_resp_o   = bypass ? s_merged : out_resp_q;
    unexpected_o = unexpected_q;
  end

  // State registers; reset discards every partial merge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q      <= '{default: 1'b0};
      rem_q        <= '{default: '0};
      acc_q        <= '{default: 2'b00};
      out_valid_q  <= 1'b0;
      out_id_q     <= '0;
      out_resp_q   <= 2'b00;
      unexpected_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      rem_q        <= rem_d;
      acc_q        <= acc_d;
      out_valid_q  <= out_valid_d;
      out_id_q     <= out_id_d;
      out_resp_q   <= out_resp_d;
      unexpected_q <= unexpected_d;
    end
  end

endmodule

// File: tb/tb_floo_mcast_rsp_merge.sv
// Directed bench for floo_mcast_rsp_merge (default build, registered output).
module tb_floo_mcast_rsp_merge;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       exp_valid_i;
  logic       exp_ready_o;
  logic [3:0] exp_id_i;
  logic [4:0] exp_count_i;
  logic       rsp_valid_i;
  logic       rsp_ready_o;
  logic [3:0] rsp_id_i;
  logic [1:0] rsp_resp_i;
  logic       rsp_valid_o;
  logic       rsp_ready_i;
  logic [3:0] rsp_id_o;
  logic [1:0] rsp_resp_o;
  logic       unexpected_o;

  int errors = 0;
  int checks = 0;

  floo_mcast_rsp_merge #(.IdWidth(4), .MaxFanout(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .exp_valid_i(exp_valid_i), .exp_ready_o(exp_ready_o),
    .exp_id_i(exp_id_i), .exp_count_i(exp_count_i),
    .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o),
    .rsp_id_i(rsp_id_i), .rsp_resp_i(rsp_resp_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o), .rsp_resp_o(rsp_resp_o),
    .unexpected_o(unexpected_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Push an expectation; the slot is assumed free.
  task automatic push(input logic [3:0] id, input logic [4:0] cnt);
    exp_valid_i = 1'b1; exp_id_i = id; exp_count_i = cnt;
    #1 chk("push_ready", 32'(exp_ready_o), 1);
    tick();
    exp_valid_i = 1'b0;
  endtask

  // Offer one response beat and check the ready seen for it.
  task automatic beat(input logic [3:0] id, input logic [1:0] resp, input int rdy);
    rsp_valid_i = 1'b1; rsp_id_i = id; rsp_resp_i = resp;
    #1 chk("beat_ready", 32'(rsp_ready_o), 32'(rdy));
    tick();
    rsp_valid_i = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int v, input int id, input int resp);
    chk({tag, "_valid"}, 32'(rsp_valid_o), 32'(v));
    if (v != 0) begin
      chk({tag, "_id"}, 32'(rsp_id_o), 32'(id));
      chk({tag, "_resp"}, 32'(rsp_resp_o), 32'(resp));
    end
  endtask

  initial begin
    rst_i = 1'b1;
    exp_valid_i = 1'b1; exp_id_i = 4'd0; exp_count_i = 5'd1;
    rsp_valid_i = 1'b1; rsp_id_i = 4'd0; rsp_resp_i = 2'd0;
    rsp_ready_i = 1'b1;
    tick(); tick();
    // Reset values, readiness forced low while in reset
    chk("rst_exp_ready", 32'(exp_ready_o), 0);
    chk("rst_rsp_ready", 32'(rsp_ready_o), 0);
    chk("rst_valid", 32'(rsp_valid_o), 0);
    chk("rst_id", 32'(rsp_id_o), 0);
    chk("rst_resp", 32'(rsp_resp_o), 0);
    chk("rst_unexp", 32'(unexpected_o), 0);
    exp_valid_i = 1'b0; rsp_valid_i = 1'b0;
    rst_i = 1'b0;
    tick();

    // Fanout merge: id 3, four OKAY beats
    push(4'd3, 5'd4);
    for (int i = 0; i < 3; i++) begin
      beat(4'd3, 2'd0, 1);
      chk_out("fan_mid", 0, 0, 0);
    end
    exp_id_i = 4'd3;
    #1 chk("fan_busy_exp_ready", 32'(exp_ready_o), 0);
    beat(4'd3, 2'd0, 1);
    chk_out("fan_done", 1, 3, 0);
    exp_id_i = 4'd3;
    #1 chk("fan_free_exp_ready", 32'(exp_ready_o), 1);
    tick();
    chk_out("fan_once", 0, 0, 0);

    // Error priority
    push(4'd1, 5'd3);
    beat(4'd1, 2'd1, 1); beat(4'd1, 2'd2, 1); beat(4'd1, 2'd3, 1);
    chk_out("prio_decerr", 1, 1, 3);
    tick();
    push(4'd2, 5'd2);
    beat(4'd2, 2'd1, 1); beat(4'd2, 2'd1, 1);
    chk_out("prio_exokay", 1, 2, 1);
    tick();
    push(4'd4, 5'd2);
    beat(4'd4, 2'd1, 1); beat(4'd4, 2'd0, 1);
    chk_out("prio_okay", 1, 4, 0);
    tick();

    // Backpressure
    rsp_ready_i = 1'b0;
    push(4'd6, 5'd1);
    push(4'd8, 5'd3);
    beat(4'd6, 2'd2, 1);
    chk_out("bp_held0", 1, 6, 2);
    beat(4'd8, 2'd1, 1);
    beat(4'd8, 2'd1, 1);
    chk_out("bp_held1", 1, 6, 2);
    rsp_valid_i = 1'b1; rsp_id_i = 4'd8; rsp_resp_i = 2'd3;
    #1 chk("bp_final_ready", 32'(rsp_ready_o), 0);
    tick();
    chk_out("bp_held2", 1, 6, 2);
    rsp_ready_i = 1'b1;
    #1 chk("bp_final_ready_rel", 32'(rsp_ready_o), 1);
    tick();
    rsp_valid_i = 1'b0;
    chk_out("bp_second", 1, 8, 3);
    tick();
    chk_out("bp_drain", 0, 0, 0);

    // Push stalled by a same-cycle non-final beat on the same ID
    push(4'd9, 5'd3);
    exp_valid_i = 1'b1; exp_id_i = 4'd9; exp_count_i = 5'd2;
    rsp_valid_i = 1'b1; rsp_id_i = 4'd9; rsp_resp_i = 2'd1;
    #1 chk("stall_exp_ready", 32'(exp_ready_o), 0);
    chk("stall_rsp_ready", 32'(rsp_ready_o), 1);
    tick();
    exp_valid_i = 1'b0; rsp_valid_i = 1'b0;

    // Slot reuse: final beat and new push for id 5 in the same cycle
    push(4'd5, 5'd2);
    beat(4'd5, 2'd0, 1);
    exp_valid_i = 1'b1; exp_id_i = 4'd5; exp_count_i = 5'd2;
    rsp_valid_i = 1'b1; rsp_id_i = 4'd5; rsp_resp_i = 2'd1;
    #1 chk("reuse_exp_ready", 32'(exp_ready_o), 1);
    chk("reuse_rsp_ready", 32'(rsp_ready_o), 1);
    tick();
    exp_valid_i = 1'b0; rsp_valid_i = 1'b0;
    chk_out("reuse_first", 1, 5, 0);
    beat(4'd5, 2'd1, 1);
    chk_out("reuse_mid", 0, 0, 0);
    beat(4'd5, 2'd1, 1);
    chk_out("reuse_second", 1, 5, 1);
    tick();

    // Edge counts: zero means one, 31 clamps to 16
    push(4'd10, 5'd0);
    beat(4'd10, 2'd2, 1);
    chk_out("cnt_zero", 1, 10, 2);
    tick();
    push(4'd11, 5'd31);
    for (int i = 0; i < 15; i++) beat(4'd11, 2'd1, 1);
    chk_out("cnt_sat_15", 0, 0, 0);
    beat(4'd11, 2'd1, 1);
    chk_out("cnt_sat_16", 1, 11, 1);
    beat(4'd11, 2'd1, 1);
    chk("cnt_sat_extra_unexp", 32'(unexpected_o), 1);
    chk_out("cnt_sat_extra", 0, 0, 0);
    tick();

    // Unexpected beat on empty id 7
    beat(4'd7, 2'd0, 1);
    chk("unexp_pulse", 32'(unexpected_o), 1);
    chk_out("unexp_noout", 0, 0, 0);
    tick();
    chk("unexp_one_cycle", 32'(unexpected_o), 0);

    // Reset in the middle of a merge
    push(4'd12, 5'd3);
    beat(4'd12, 2'd0, 1);
    rst_i = 1'b1;
    #1 chk("mid_rst_valid", 32'(rsp_valid_o), 0);
    chk("mid_rst_id", 32'(rsp_id_o), 0);
    chk("mid_rst_resp", 32'(rsp_resp_o), 0);
    chk("mid_rst_unexp", 32'(unexpected_o), 0);
    chk("mid_rst_rsp_ready", 32'(rsp_ready_o), 0);
    tick();
    rst_i = 1'b0;
    exp_id_i = 4'd12;
    #1 chk("post_rst_exp_ready", 32'(exp_ready_o), 1);
    beat(4'd12, 2'd0, 1);
    chk("post_rst_unexp", 32'(unexpected_o), 1);
    chk_out("post_rst_noout", 0, 0, 0);
    tick();
    chk("post_rst_unexp_clr", 32'(unexpected_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
